// File: rtl/serial_nbit_comparator.sv
// serial_nbit_comparator
//
// Multi-cycle magnitude comparator. Two N-bit operands are compared DIGIT
// bits per cycle, most significant digit first, in unsigned or
// two's-complement mode. The result keeps the 1 / -1 / 0 encoding of the
// combinational comparator: result = 2'b01 (A > B), 2'b11 (A < B),
// 2'b00 (A == B). Flags are registered and held until the next compare
// completes.
//
// Compile-time option:
//   CMP_EARLY_EXIT_EN  defined   -> RUN stops on the first differing digit
//                                   (latency 2 .. D+1 cycles)
//                      undefined -> RUN always walks all D digits
//                                   (latency D+1 cycles), same flag values
//
// Parameters:
//   N      operand width (>= 2)
//   DIGIT  bits compared per cycle; N must be a multiple of DIGIT
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset; aborts any compare
//   start        request, sampled while not busy (IDLE or DONE)
//   a, b         operands, captured on accepted start
//   signed_mode  0 = unsigned, 1 = two's complement; captured on start
//   busy         high while a compare is running
//   done         one-cycle pulse when the result flags update
//   gt, lt, eq   held comparison flags
//   result       held 2-bit signed result code
//
// States:
//   state  | meaning
//   S_IDLE | waiting for start, flags hold last result
//   S_RUN  | comparing one digit per cycle
//   S_DONE | result registered, done pulse; start accepted here too

module serial_nbit_comparator #(
   parameter int N     = 16,
   parameter int DIGIT = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         signed_mode,
   output logic         busy,
   output logic         done,
   output logic         gt,
   output logic         lt,
   output logic         eq,
   output logic [1:0]   result
);

   localparam int D  = N / DIGIT;
   localparam int IW = (D > 1) ? $clog2(D) : 1;

   generate
      if ((N < 2) || (DIGIT < 1) || ((N % DIGIT) != 0)) begin : g_bad_param
         $error("serial_nbit_comparator: N must be >= 2 and a multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   a_q, a_d;
   logic [N-1:0]   b_q, b_d;
   logic           smode_q, smode_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           gt_q, gt_d;
   logic           lt_q, lt_d;
   logic           eq_q, eq_d;
   logic [1:0]     result_q, result_d;

`ifndef CMP_EARLY_EXIT_EN
   // First difference seen during the full walk; later digits cannot override it.
   logic           dec_q, dec_d;
   logic           dec_gt_q, dec_gt_d;
`endif

   logic [DIGIT-1:0] dig_a;
   logic [DIGIT-1:0] dig_b;
   logic             dig_gt;
   logic             dig_lt;
   logic             last_dig;

   // Operand registers shift left each RUN cycle, so the digit under
   // compare is always the top DIGIT bits. On the MSB digit in signed mode
   // the sign bits are inverted, which maps two's-complement order onto
   // unsigned order.
   always_comb begin
      dig_a = a_q[N-1 -: DIGIT];
      dig_b = b_q[N-1 -: DIGIT];
      if (smode_q && (idx_q == '0)) begin
         dig_a[DIGIT-1] = ~a_q[N-1];
         dig_b[DIGIT-1] = ~b_q[N-1];
      end
      dig_gt   = (dig_a > dig_b);
      dig_lt   = (dig_a < dig_b);
      last_dig = (idx_q == IW'(D - 1));
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      smode_d  = smode_q;
      idx_d    = idx_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      gt_d     = gt_q;
      lt_d     = lt_q;
      eq_d     = eq_q;
      result_d = result_q;
`ifndef CMP_EARLY_EXIT_EN
      dec_d    = dec_q;
      dec_gt_d = dec_gt_q;
`endif

      case (state_q)
         S_RUN: begin
            busy_d = 1'b1;
            a_d    = a_q << DIGIT;
            b_d    = b_q << DIGIT;
            idx_d  = idx_q + 1'b1;
`ifdef CMP_EARLY_EXIT_EN
            if (dig_gt || dig_lt) begin
               state_d  = S_DONE;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               gt_d     = dig_gt;
               lt_d     = dig_lt;
               eq_d     = 1'b0;
               result_d = dig_gt ? 2'b01 : 2'b11;
            end else if (last_dig) begin
               state_d  = S_DONE;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               gt_d     = 1'b0;
               lt_d     = 1'b0;
               eq_d     = 1'b1;
               result_d = 2'b00;
            end
`else
            if (!dec_q && (dig_gt || dig_lt)) begin
               dec_d    = 1'b1;
               dec_gt_d = dig_gt;
            end
            if (last_dig) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               if (dec_d) begin
                  gt_d     = dec_gt_d;
                  lt_d     = ~dec_gt_d;
                  eq_d     = 1'b0;
                  result_d = dec_gt_d ? 2'b01 : 2'b11;
               end else begin
                  gt_d     = 1'b0;
                  lt_d     = 1'b0;
                  eq_d     = 1'b1;
                  result_d = 2'b00;
               end
            end
`endif
         end

         default: begin
            // S_IDLE and S_DONE both accept a new request.
            state_d = S_IDLE;
            if (start) begin
               state_d = S_RUN;
               busy_d  = 1'b1;
               a_d     = a;
               b_d     = b;
               smode_d = signed_mode;
               idx_d   = '0;
`ifndef CMP_EARLY_EXIT_EN
               dec_d    = 1'b0;
               dec_gt_d = 1'b0;
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         smode_q  <= 1'b0;
         idx_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         gt_q     <= 1'b0;
         lt_q     <= 1'b0;
         eq_q     <= 1'b0;
         result_q <= 2'b00;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         smode_q  <= smode_d;
         idx_q    <= idx_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         gt_q     <= gt_d;
         lt_q     <= lt_d;
         eq_q     <= eq_d;
         result_q <= result_d;
      end
   end

`ifndef CMP_EARLY_EXIT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dec_q    <= 1'b0;
         dec_gt_q <= 1'b0;
      end else begin
         dec_q    <= dec_d;
         dec_gt_q <= dec_gt_d;
      end
   end
`endif

   assign busy   = busy_q;
   assign done   = done_q;
   assign gt     = gt_q;
   assign lt     = lt_q;
   assign eq     = eq_q;
   assign result = result_q;

endmodule

// File: tb/tb_serial_nbit_comparator.sv
// Directed-vector bench for serial_nbit_comparator (N=16, DIGIT=4).
// Expected done cycles follow CMP_EARLY_EXIT_EN when it is defined for the build.

module tb_serial_nbit_comparator;

   localparam int N     = 16;
   localparam int DIGIT = 4;
   localparam int D     = N / DIGIT;
`ifdef CMP_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         signed_mode;
   logic         busy;
   logic         done;
   logic         gt;
   logic         lt;
   logic         eq;
   logic [1:0]   result;

   int n_checks;
   int n_errors;

   serial_nbit_comparator #(.N(N), .DIGIT(DIGIT)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .a           (a),
      .b           (b),
      .signed_mode (signed_mode),
      .busy        (busy),
      .done        (done),
      .gt          (gt),
      .lt          (lt),
      .eq          (eq),
      .result      (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic int done_cyc(input int dec_idx);
      return EE ? (2 + dec_idx) : (D + 1);
   endfunction

   // Called #1 after the edge opening cycle 0 with start already driven high.
   // Returns #1 into the done cycle (or after the timeout).
   task automatic wait_done(input string tag, input logic [1:0] exp_res, input int exp_cyc);
      int cyc;
      int busy_cnt;
      next_cyc();
      start = 1'b0;
      cyc = 1;
      busy_cnt = 0;
      chk({tag, "_busy_c1"}, busy, 1);
      while (done !== 1'b1 && cyc < 30) begin
         if (busy === 1'b1) busy_cnt++;
         next_cyc();
         cyc++;
      end
      chk({tag, "_done_cyc"}, cyc, exp_cyc);
      chk({tag, "_busy_cnt"}, busy_cnt, exp_cyc - 1);
      chk({tag, "_busy_at_done"}, busy, 0);
      chk({tag, "_result"}, result, exp_res);
      chk({tag, "_flags"}, {gt, lt, eq},
          (exp_res == 2'b01) ? 3'b100 : (exp_res == 2'b11) ? 3'b010 : 3'b001);
   endtask

   task automatic issue(input logic [N-1:0] va, input logic [N-1:0] vb, input logic sm);
      a = va;
      b = vb;
      signed_mode = sm;
      start = 1'b1;
   endtask

   initial begin
      int done_cnt;
      int done_at;
      logic [1:0] res_at;

      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      signed_mode = 1'b0;
      repeat (2) next_cyc();
      chk("rst_outputs", {busy, done, gt, lt, eq, result}, 7'b0);
      rst = 1'b0;
      next_cyc();
      chk("idle_outputs", {busy, done, gt, lt, eq, result}, 7'b0);

      // unsigned, difference only in last digit
      issue(16'h1234, 16'h1235, 1'b0);
      wait_done("u_1234_1235", 2'b11, D + 1);
      next_cyc();
      chk("done_one_cycle", done, 0);
      chk("result_held", {lt, result}, 3'b111);

      // unsigned, difference on digit 0
      issue(16'hF000, 16'h0FFF, 1'b0);
      wait_done("u_f000_0fff", 2'b01, done_cyc(0));
      next_cyc();

      // signed, same bits, opposite ordering
      issue(16'hF000, 16'h0FFF, 1'b1);
      wait_done("s_f000_0fff", 2'b11, done_cyc(0));
      next_cyc();

      // signed equal, then back-to-back start in the done cycle
      issue(16'h8000, 16'h8000, 1'b1);
      wait_done("s_8000_8000", 2'b00, D + 1);
      issue(16'h7FFF, 16'h8000, 1'b1);
      wait_done("b2b_7fff_8000", 2'b01, done_cyc(0));
      next_cyc();

      // input isolation: start held 3 cycles with operands changing
      issue(16'h0001, 16'h0002, 1'b0);
      done_cnt = 0;
      done_at = 0;
      res_at = 2'b10;
      for (int c = 1; c <= 10; c++) begin
         next_cyc();
         if (c == 1) begin a = 16'hFFFF; b = 16'h0000; end
         if (c == 2) begin a = 16'h0000; b = 16'hFFFF; signed_mode = 1'b1; end
         if (c == 3) start = 1'b0;
         if (done === 1'b1) begin
            done_cnt++;
            done_at = c;
            res_at = result;
         end
      end
      chk("iso_done_count", done_cnt, 1);
      chk("iso_done_cyc", done_at, D + 1);
      chk("iso_result", res_at, 2'b11);
      chk("iso_idle_after", busy, 0);

      // reset in cycle 2 of a compare
      issue(16'h1234, 16'h1235, 1'b0);
      next_cyc();
      start = 1'b0;
      next_cyc();
      chk("rst_mid_busy_before", busy, 1);
      rst = 1'b1;
      #1;
      chk("rst_mid_outputs", {busy, done, gt, lt, eq, result}, 7'b0);
      next_cyc();
      rst = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         next_cyc();
         if (done === 1'b1 || busy === 1'b1) done_cnt++;
      end
      chk("rst_mid_no_done", done_cnt, 0);
      chk("rst_mid_flags_after", {gt, lt, eq, result}, 5'b0);

      issue(16'hF000, 16'h0FFF, 1'b0);
      wait_done("post_rst", 2'b01, done_cyc(0));

      // signed, decision in digit 2
      next_cyc();
      issue(16'hFF80, 16'hFF7F, 1'b1);
      wait_done("s_ff80_ff7f", 2'b01, done_cyc(2));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
